// File: rtl/arf_pkg.sv
// Shared constants, write-FSM state type and operand-slot mapping for the ARF front end.
package arf_pkg;

    localparam int ARF_DATA_W = 16;
    localparam int ARF_N_MUL1 = 8;

    typedef enum logic {
        FILL = 1'b0,
        DROP = 1'b1
    } wr_state_t;

    // Frame slot feeding first-level multiplier mul (1-based), input in_sel (0/1).
    function automatic int slot(input int mul, input int in_sel);
        return 2 * (mul - 1) + in_sel;
    endfunction

endpackage

// File: rtl/arf_frame_bank.sv
// One frame of operand words: single write port, every word readable in parallel.
module arf_frame_bank #(
    parameter int DATA_W = 16,
    parameter int N_OPS  = 16,
    parameter int AW     = $clog2(N_OPS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_we,
    input  logic [AW-1:0]             i_addr,
    input  logic [DATA_W-1:0]         i_wdata,
    output logic [N_OPS*DATA_W-1:0]   o_data
);

    logic [DATA_W-1:0] r_mem [N_OPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_OPS; k++) begin
                r_mem[k] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_comb begin
        o_data = '0;
        for (int k = 0; k < N_OPS; k++) begin
            o_data[k*DATA_W +: DATA_W] = r_mem[k];
        end
    end

endmodule

// File: rtl/arf_frame_loader.sv
// Double-buffered serial-to-parallel frame loader: s-side words in, whole frames out on m-side.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module arf_frame_loader
    import arf_pkg::*;
#(
    parameter int DATA_W = ARF_DATA_W,
    parameter int N_OPS  = 2 * ARF_N_MUL1,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [N_OPS*DATA_W-1:0]  m_data,
    output logic                     err_short,
    output logic                     err_long,
    input  logic                     err_clr,
    output logic [CNT_W-1:0]         frame_cnt,
    output wr_state_t                dbg_state
);

    localparam int AW = $clog2(N_OPS);
    localparam logic [AW-1:0] LAST_SLOT = AW'(N_OPS - 1);

    wr_state_t          r_state;
    logic [AW-1:0]      r_wr_cnt;
    logic [1:0]         r_full;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic               r_err_short;
    logic               r_err_long;
    logic [CNT_W-1:0]   r_frame_cnt;

    wr_state_t          w_state_nxt;
    logic [AW-1:0]      w_cnt_nxt;
    logic               w_s_ready;
    logic               w_we;
    logic               w_set_full;
    logic               w_set_short;
    logic               w_set_long;
    logic               w_drain;
    logic [1:0]         w_full_nxt;
    logic [N_OPS*DATA_W-1:0] w_bank0_data;
    logic [N_OPS*DATA_W-1:0] w_bank1_data;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wr_cnt;
        w_s_ready   = 1'b1;
        w_we        = 1'b0;
        w_set_full  = 1'b0;
        w_set_short = 1'b0;
        w_set_long  = 1'b0;
        case (r_state)
            FILL: begin
                w_s_ready = !r_full[r_wr_bank];
                if (s_valid && w_s_ready) begin
                    w_we = 1'b1;
                    if (r_wr_cnt == LAST_SLOT) begin
                        w_cnt_nxt = '0;
                        if (s_last) begin
                            w_set_full = 1'b1;
                        end else begin
                            w_set_long  = 1'b1;
                            w_state_nxt = DROP;
                        end
                    end else if (s_last) begin
                        w_cnt_nxt   = '0;
                        w_set_short = 1'b1;
                    end else begin
                        w_cnt_nxt = r_wr_cnt + AW'(1);
                    end
                end
            end
            DROP: begin
                if (s_valid && s_last) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // A bank cannot complete and drain in the same cycle, so both updates are independent.
    always_comb begin
        w_drain    = r_full[r_rd_bank] && m_ready;
        w_full_nxt = r_full;
        if (w_drain)    w_full_nxt[r_rd_bank] = 1'b0;
        if (w_set_full) w_full_nxt[r_wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_wr_cnt    <= '0;
            r_full      <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_cnt <= w_cnt_nxt;
            r_full   <= w_full_nxt;
            if (w_set_full) r_wr_bank <= !r_wr_bank;
            if (w_drain) begin
                r_rd_bank   <= !r_rd_bank;
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
            // A new error outranks a coincident clear.
            if (w_set_short)  r_err_short <= 1'b1;
            else if (err_clr) r_err_short <= 1'b0;
            if (w_set_long)   r_err_long  <= 1'b1;
            else if (err_clr) r_err_long  <= 1'b0;
        end
    end

    arf_frame_bank #(.DATA_W(DATA_W), .N_OPS(N_OPS), .AW(AW)) u_bank0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we && !r_wr_bank),
        .i_addr  (r_wr_cnt),
        .i_wdata (s_data),
        .o_data  (w_bank0_data)
    );

    arf_frame_bank #(.DATA_W(DATA_W), .N_OPS(N_OPS), .AW(AW)) u_bank1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we && r_wr_bank),
        .i_addr  (r_wr_cnt),
        .i_wdata (s_data),
        .o_data  (w_bank1_data)
    );

    assign s_ready   = w_s_ready;
    assign m_valid   = r_full[r_rd_bank];
    assign m_data    = r_rd_bank ? w_bank1_data : w_bank0_data;
    assign err_short = r_err_short;
    assign err_long  = r_err_long;
    assign frame_cnt = r_frame_cnt;
    assign dbg_state = r_state;

endmodule
